// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state encoding.
// Also used by the SERIAL_ADDER_OVF_EN build of serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder request/result bundle.
// overflow exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, in1, in2, carry_in,
    input  busy, done, sum, carry_out
`ifdef SERIAL_ADDER_OVF_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, in1, in2, carry_in,
    output busy, done, sum, carry_out
`ifdef SERIAL_ADDER_OVF_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/full_from_half.sv
// Full adder cell composed of two half-adder stages.
// Single bit-slice used by serial_adder.
module full_from_half (
  output logic sum,
  output logic carry_out,
  input  logic in1,
  input  logic in2,
  input  logic carry_in
);
  logic hs;
  logic hc1;
  logic hc2;

  assign hs        = in1 ^ in2;
  assign hc1       = in1 & in2;
  assign sum       = hs ^ carry_in;
  assign hc2       = hs & carry_in;
  assign carry_out = hc1 | hc2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_nx;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fs;
  logic             fc;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  full_from_half u_fa (
    .sum       (fs),
    .carry_out (fc),
    .in1       (a[0]),
    .in2       (b[0]),
    .carry_in  (c)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign s_nx = (s >> 1) | (WIDTH'(fs) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // DONE re-arms straight into RUN so back-to-back adds take WIDTH+1 cycles
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load = bus.start;
        if (bus.start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        load     = bus.start;
        state_nx = bus.start ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      s      <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a   <= bus.in1;
      b   <= bus.in2;
      c   <= bus.carry_in;
      cnt <= '0;
    end else if (step) begin
      a   <= a >> 1;
      b   <= b >> 1;
      s   <= s_nx;
      c   <= fc;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum_q  <= s_nx;
        cout_q <= fc;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // c holds the carry into the MSB while the last bit is evaluated
  always_ff @(posedge clk) begin
    if (!rst_n)             ovf_q <= 1'b0;
    else if (step && last)  ovf_q <= c ^ fc;
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder, WIDTH=8 and WIDTH=1.
// Checks overflow too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntest = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) x8 ();
  serial_adder_if #(.WIDTH(1)) x1 ();

  serial_adder #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (x8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (x1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // signed overflow from operand/result signs
  function automatic logic sovf(input logic sa, input logic sb,
                                input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // called at a negedge; returns at the negedge showing done
  task automatic add8(input logic [7:0] a, input logic [7:0] b,
                      input logic ci);
    logic [8:0] exp9;
    int lat;
    exp9 = {1'b0, a} + {1'b0, b} + 9'(ci);
    x8.start    = 1'b1;
    x8.in1      = a;
    x8.in2      = b;
    x8.carry_in = ci;
    @(posedge clk);
    @(negedge clk);
    x8.start = 1'b0;
    lat = 0;
    while (!x8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("lat8", lat, 8);
    chk("sum8", {x8.carry_out, x8.sum}, exp9);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf8", x8.overflow, sovf(a[7], b[7], exp9[7]));
`endif
  endtask

  task automatic add1(input logic a, input logic b, input logic ci);
    logic [1:0] exp2;
    int lat;
    exp2 = 2'(a) + 2'(b) + 2'(ci);
    x1.start    = 1'b1;
    x1.in1      = a;
    x1.in2      = b;
    x1.carry_in = ci;
    @(posedge clk);
    @(negedge clk);
    x1.start = 1'b0;
    lat = 0;
    while (!x1.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("lat1", lat, 1);
    chk("sum1", {x1.carry_out, x1.sum}, exp2);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf1", x1.overflow, sovf(a, b, exp2[0]));
`endif
  endtask

  initial begin
    int nd;
    int dl;
    logic d2;
    logic [8:0] s1;
    logic [8:0] s2;
    logic [7:0] ra;
    logic [7:0] rb;

    x8.start = 1'b0; x8.in1 = '0; x8.in2 = '0; x8.carry_in = 1'b0;
    x1.start = 1'b0; x1.in1 = '0; x1.in2 = '0; x1.carry_in = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", x8.busy, 0);
    chk("rst_done", x8.done, 0);
    chk("rst_sum", {x8.carry_out, x8.sum}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", x8.overflow, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    add8(8'h5A, 8'h3C, 1'b0);
    chk("t1_sum", x8.sum, 8'h96);
    @(negedge clk);
    chk("t1_busy", x8.busy, 0);
    chk("t1_done", x8.done, 0);

    add8(8'hFF, 8'h01, 1'b0);
    chk("t2_cout", x8.carry_out, 1);
    @(negedge clk);
    add8(8'h7F, 8'h01, 1'b0);
    chk("t2_sum80", x8.sum, 8'h80);
    @(negedge clk);

    // start held high, operands changed after accept
    x8.start    = 1'b1;
    x8.in1      = 8'h12;
    x8.in2      = 8'h34;
    x8.carry_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x8.in1      = 8'hA5;
    x8.in2      = 8'hC3;
    x8.carry_in = 1'b0;
    nd = 0; dl = -1; d2 = 1'b0; s1 = '0; s2 = '0;
    for (int l = 0; l <= 17; l++) begin
      if (l > 0) @(negedge clk);
      if (x8.done) begin
        if (l <= 16) begin
          nd++;
          dl = l;
          s1 = {x8.carry_out, x8.sum};
        end else begin
          d2 = 1'b1;
          s2 = {x8.carry_out, x8.sum};
        end
      end
    end
    x8.start = 1'b0;
    chk("t3_ndone", nd, 1);
    chk("t3_dlat", dl, 8);
    chk("t3_sum", s1, 9'h047);
    chk("t3_reacc", d2, 1);
    chk("t3_sum2", s2, 9'h168);
    @(negedge clk);

    // reset in the middle of RUN
    x8.start    = 1'b1;
    x8.in1      = 8'h0F;
    x8.in2      = 8'h0F;
    x8.carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    x8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy_pre", x8.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_busy", x8.busy, 0);
    chk("t4_done", x8.done, 0);
    chk("t4_sum", x8.sum, 0);
    chk("t4_cout", x8.carry_out, 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (x8.done) nd++;
    end
    chk("t4_nodone", nd, 0);

    for (int i = 0; i < 8; i++) begin
      add1(1'(i >> 2), 1'(i >> 1), 1'(i));
    end
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      add8(ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
